uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It captures each byte presented with the receiver's one-cycle done strobe and holds it in a first-word-fall-through FIFO. The MMIO UART core reads bytes out of it at its own pace. The block reports occupancy, full/empty/almost-full status and a sticky overrun flag, so software can detect bytes lost while the buffer was full.

## Interface
- DATA_WIDTH, 8, width of each stored word (matches receiver output byte)
- ADDR_WIDTH, 4, pointer width; depth = 2^ADDR_WIDTH (16 entries)
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL (legal range 1..2^ADDR_WIDTH)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr  in  1  write strobe, connected to receiver done tick (one-cycle pulse)
- wr_data  in  DATA_WIDTH  byte to store, sampled when wr=1
- rd  in  1  read/pop strobe from MMIO read of the data register
- clr_overrun  in  1  one-cycle pulse that clears the overrun flag
- rd_data  out  DATA_WIDTH  head-of-FIFO word (first-word-fall-through)
- empty  out  1  no stored words
- full  out  1  count == 2^ADDR_WIDTH
- almost_full  out  1  count >= AF_LEVEL
- count  out  ADDR_WIDTH+1  number of stored words, 0..2^ADDR_WIDTH
- overrun  out  1  sticky flag: a write was dropped because the FIFO was full

## Operation
- Storage: 2^ADDR_WIDTH x DATA_WIDTH register array. Write pointer w_ptr and read pointer r_ptr are ADDR_WIDTH bits and wrap modulo depth (15 -> 0). count is a separate ADDR_WIDTH+1-bit register.
- Status: empty = (count==0), full = (count==depth), almost_full = (count>=AF_LEVEL). All are decoded from registered count, with no combinational path from wr/rd.
- rd_data = mem[r_ptr], continuously driven. Valid only while empty=0. No read latency: the head word is visible before rd is asserted.
- Accepted write (wr=1 and either not full, or full with rd=1): mem[w_ptr] <= wr_data; w_ptr increments.
- Accepted read (rd=1 and not empty): r_ptr increments. The popped word is the value shown on rd_data in that same cycle.
- count update: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted write and read.
- Boundary cases:
  - rd while empty: ignored, and no pointer or count change. This applies even when wr=1 in the same cycle: the write is accepted and count becomes 1.
  - wr while full, rd=0: data dropped, pointers and count unchanged, overrun <= 1.
  - wr and rd both asserted while full: both accepted, count stays at depth, no overrun.
- overrun:
  - Set on any dropped write.
  - Cleared by clr_overrun.
  - If a set and a clear occur in the same cycle, set wins.
- Reset (asynchronous, any time, including mid-fill):
  - w_ptr = r_ptr = 0, count = 0, overrun = 0.
  - All storage cleared to 0.
  - Resulting outputs: empty=1, full=0, almost_full=0, count=0, overrun=0, rd_data=0.
  - Any in-flight wr/rd in the reset cycle is discarded.

## Timing
- All state updates on rising clk. Outputs change only after a clock edge or on reset assertion.
- Write-to-visibility latency: 1 cycle. After the wr edge into an empty FIFO, empty=0 and rd_data=wr_data in the following cycle.
- Pop latency: 1 cycle. After the rd edge, rd_data shows the next word, or empty=1 if the FIFO is drained.
- Status flags and count reflect the same edge as the pointer update. Sustained throughput is one write and one read per cycle.
- Behaviour does not depend on wr being a single-cycle pulse: each cycle with wr=1 is a separate write, and likewise each cycle with rd=1 is a separate read.

## Test plan
- Single byte: after reset, wr=1 with wr_data=0xA5 for one cycle -> next cycle empty=0, count=1, rd_data=0xA5. Then rd=1 for one cycle -> empty=1, count=0.
- Fill to full: write 0x00..0x0F on 16 consecutive cycles -> almost_full rises when count reaches 12, full=1 at count=16, overrun=0. Drain with 16 reads -> data returned in order 0x00..0x0F, then empty=1.
- Overflow: with the FIFO full, write 0xEE -> overrun=1, count=16, and the entry is not stored (the drain sequence is still 0x00..0x0F). Pulse clr_overrun -> overrun=0. Then clr_overrun together with a dropped write -> overrun stays 1.
- Wrap-around and simultaneous operations:
  - Interleave 40 writes with reads, keeping 3 words in flight -> pointers wrap at least twice and every byte is returned in order.
  - wr+rd while full -> count stays 16, no overrun.
  - wr+rd while empty -> count=1, rd_data = the written byte.
- Reset mid-operation: load 7 bytes, assert reset asynchronously mid-cycle -> empty=1, count=0, overrun=0, rd_data=0 immediately. A subsequent write of 0x3C reads back 0x3C.
- Empty read: rd=1 on an empty FIFO for 3 cycles -> count stays 0, no pointer movement. A following single write and read returns the correct byte.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer between the UART receiver and the MMIO core.
// Tracks occupancy and raises a sticky overrun flag when a byte is lost.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd,
  input  logic                  clr_overrun,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overrun
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_C    = AF_LEVEL[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overrun_q, overrun_d;

  logic full_s, empty_s, wr_ok, rd_ok, wr_drop;

  assign full_s  = (count_q == DEPTH_C);
  assign empty_s = (count_q == '0);
  // A full FIFO can still accept a write when a pop frees a slot in the same cycle.
  assign rd_ok   = rd & ~empty_s;
  assign wr_ok   = wr & (~full_s | rd);
  assign wr_drop = wr & full_s & ~rd;

  always_comb begin
    w_ptr_d   = w_ptr_q;
    r_ptr_d   = r_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (wr_ok) w_ptr_d = w_ptr_q + 1'b1;
    if (rd_ok) r_ptr_d = r_ptr_q + 1'b1;
    if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
    else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
    // Set has priority so a drop in the clearing cycle is not lost.
    if (wr_drop)          overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_q   <= '0;
      r_ptr_q   <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      w_ptr_q   <= w_ptr_d;
      r_ptr_q   <= r_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[w_ptr_q] <= wr_data;
    end
  end

  assign rd_data     = mem_q[r_ptr_q];
  assign empty       = empty_s;
  assign full        = full_s;
  assign almost_full = (count_q >= AF_C);
  assign count       = count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue-based reference model tracks
// expected contents and flags; a negedge monitor compares against the DUT.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd = 1'b0;
  logic       clr_overrun = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full, almost_full, overrun;
  logic [4:0] count;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  bit         exp_ovr = 1'b0;

  uart_rx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(AF)) dut (
    .clk(clk), .reset(reset), .wr(wr), .wr_data(wr_data), .rd(rd),
    .clr_overrun(clr_overrun), .rd_data(rd_data), .empty(empty), .full(full),
    .almost_full(almost_full), .count(count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue, updated from the inputs seen at each edge.
  always @(posedge clk) begin
    int  sz;
    bit  m_full, do_rd, do_wr;
    if (!reset) begin
      sz     = exp_q.size();
      m_full = (sz == DEPTH);
      do_rd  = rd && (sz > 0);
      do_wr  = wr && (!m_full || rd);
      if (wr && m_full && !rd) exp_ovr = 1'b1;
      else if (clr_overrun)    exp_ovr = 1'b0;
      if (do_rd) void'(exp_q.pop_front());
      if (do_wr) exp_q.push_back(wr_data);
    end
  end

  // Monitor: status every cycle; the head word whenever the FIFO holds data.
  always @(negedge clk) begin
    int sz;
    sz = exp_q.size();
    chk("count", 32'(count), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(sz >= AF));
    chk("overrun", 32'(overrun), 32'(exp_ovr));
    if (sz > 0) chk(rd ? "rd_data_pop" : "rd_data_head", 32'(rd_data), 32'(exp_q[0]));
  end

  task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit c);
    wr = w; wr_data = d; rd = r; clr_overrun = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic mid_cycle_reset(input logic [7:0] inflight);
    wr = 1'b1; wr_data = inflight; rd = 1'b1;
    #2;
    reset = 1'b1;
    exp_q.delete();
    exp_ovr = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    #1;
    chk("init_rst_empty", 32'(empty), 32'd1);
    chk("init_rst_rd_data", 32'(rd_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    // Single byte
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("single_visible", 32'(rd_data), 32'h0A5);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);

    // Fill, overflow, clear, clear racing a drop, wr+rd while full, drain
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("overflow_flag", 32'(overrun), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("overrun_cleared", 32'(overrun), 32'd0);
    cyc(1'b1, 8'hEF, 1'b0, 1'b1);
    chk("set_beats_clear", 32'(overrun), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    chk("full_wr_rd_count", 32'(count), 32'd16);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);

    // Reads on empty, then wr+rd while empty
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("empty_wr_rd_data", 32'(rd_data), 32'h05A);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // 40 writes with three words in flight
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 3; i < 40; i++) cyc(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);

    // Reset while partly filled, then reuse
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    mid_cycle_reset(8'h99);
    idle(1);
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("post_reset_data", 32'(rd_data), 32'h03C);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomised traffic alternating fill-heavy and drain-heavy phases
    for (int i = 0; i < 3000; i++) begin
      bit fill_phase;
      fill_phase = ((i / 60) % 2) == 0;
      cyc(($urandom_range(0, 3) != 0) == fill_phase,
          8'($urandom),
          ($urandom_range(0, 3) != 0) != fill_phase,
          $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
